xdma_write_resp_tracker: RTL and testbench

//  Downstream companion of the XDMA write-request backend. Records every issued AW burst

---
 rtl/xdma_pkg.sv | 24 ++
 rtl/xdma_b_track_fifo.sv | 54 +++++
 rtl/xdma_write_resp_tracker.sv | 129 ++++++++++++
 tb/tb_xdma_write_resp_tracker.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xdma_pkg.sv
// Shared types for the XDMA write-response path.
// Request index, AXI B codes and the per-burst tracking record.
package xdma_pkg;

  localparam int XdmaIdxWidth = 4;

  typedef logic [XdmaIdxWidth-1:0] xdma_req_idx_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef struct packed {
    xdma_req_idx_t idx;
    logic          is_last;
  } xdma_b_track_t;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/xdma_b_track_fifo.sv
// Non-fall-through FIFO of issued AW bursts awaiting their B.
// Extra pointer bit distinguishes full from empty.
module xdma_b_track_fifo
  import xdma_pkg::*;
#(
  parameter int  Depth  = 8,
  parameter type T      = xdma_b_track_t,
  parameter int  UsageW = $clog2(Depth + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  T                  wdata,
  input  logic              pop,
  output T                  rdata,
  output logic              full,
  output logic              empty,
  output logic [UsageW-1:0] usage
);

  localparam int AW = $clog2(Depth);

  T              mem [Depth];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_push;
  logic          do_pop;

  assign usage   = UsageW'(wptr - rptr);
  assign full    = (usage == UsageW'(Depth));
  assign empty   = (wptr == rptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr[AW-1:0]];

  // Storage write; contents need no reset since pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  // Pointer update; reset empties the queue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/xdma_write_resp_tracker.sv
// Tracks issued AW bursts, consumes in-order B responses and
// emits one completion record per XDMA request.
module xdma_write_resp_tracker
  import xdma_pkg::*;
#(
  parameter int OutstandingDepth = 8,
  parameter int IdxWidth         = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  aw_issue_valid_i,
  output logic                                  aw_issue_ready_o,
  input  logic [IdxWidth-1:0]                   aw_issue_idx_i,
  input  logic                                  aw_issue_last_i,
  input  logic                                  b_valid_i,
  output logic                                  b_ready_o,
  input  logic [1:0]                            b_resp_i,
  output logic                                  done_valid_o,
  input  logic                                  done_ready_i,
  output logic [IdxWidth-1:0]                   done_idx_o,
  output logic                                  done_err_o,
  output logic [7:0]                            done_bursts_o,
  output logic [$clog2(OutstandingDepth+1)-1:0] outstanding_o,
  output logic                                  busy_o
);

  localparam int UsageW = $clog2(OutstandingDepth + 1);

  typedef struct packed {
    logic [IdxWidth-1:0] idx;
    logic                is_last;
  } track_t;

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } out_state_e;

  track_t     wr_rec;
  track_t     head;
  logic       full;
  logic       empty;
  logic       push;
  logic       b_hs;
  logic       bad;
  logic       last_b;
  logic       stall;
  logic       err_acc;
  logic [7:0] burst_cnt;
  out_state_e state;

  assign wr_rec.idx     = aw_issue_idx_i;
  assign wr_rec.is_last = aw_issue_last_i;

  assign aw_issue_ready_o = ~full;
  assign push             = aw_issue_valid_i & ~full;
  assign stall            = done_valid_o & ~done_ready_i;
  assign b_ready_o        = ~empty & ~stall;
  assign b_hs             = b_valid_i & b_ready_o;
  assign bad              = (b_resp_i == AXI_RESP_SLVERR) |
                            (b_resp_i == AXI_RESP_DECERR);
  assign last_b           = b_hs & head.is_last;
  assign done_valid_o     = (state == S_FULL);
  assign busy_o           = (outstanding_o != '0) | done_valid_o;

  xdma_b_track_fifo #(
    .Depth  (OutstandingDepth),
    .T      (track_t),
    .UsageW (UsageW)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .wdata (wr_rec),
    .pop   (b_hs),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .usage (outstanding_o)
  );

  // Per-request error and burst accumulators; cleared on the last B.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_acc   <= 1'b0;
      burst_cnt <= 8'd0;
    end else if (b_hs) begin
      if (head.is_last) begin
        err_acc   <= 1'b0;
        burst_cnt <= 8'd0;
      end else begin
        err_acc   <= err_acc | bad;
        burst_cnt <= sat_inc8(burst_cnt);
      end
    end
  end

  // Completion register: loads on last B, clears on accept.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= S_EMPTY;
      done_idx_o    <= '0;
      done_err_o    <= 1'b0;
      done_bursts_o <= 8'd0;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (last_b) begin
            state         <= S_FULL;
            done_idx_o    <= head.idx;
            done_err_o    <= err_acc | bad;
            done_bursts_o <= sat_inc8(burst_cnt);
          end
        end
        S_FULL: begin
          if (last_b) begin
            done_idx_o    <= head.idx;
            done_err_o    <= err_acc | bad;
            done_bursts_o <= sat_inc8(burst_cnt);
          end else if (done_ready_i) begin
            state <= S_EMPTY;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_xdma_write_resp_tracker.sv
// Bench for xdma_write_resp_tracker: queue-level reference model
// checked every cycle, plus literal checks of the completion log.
module tb_xdma_write_resp_tracker;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       aw_v;
  logic       aw_rdy;
  logic [3:0] aw_idx;
  logic       aw_last;
  logic       b_v;
  logic       b_rdy;
  logic [1:0] b_resp;
  logic       d_v;
  logic       d_rdy;
  logic [3:0] d_idx;
  logic       d_err;
  logic [7:0] d_bursts;
  logic [3:0] outst;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xdma_write_resp_tracker #(
    .OutstandingDepth (D),
    .IdxWidth         (4)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .aw_issue_valid_i (aw_v),
    .aw_issue_ready_o (aw_rdy),
    .aw_issue_idx_i   (aw_idx),
    .aw_issue_last_i  (aw_last),
    .b_valid_i        (b_v),
    .b_ready_o        (b_rdy),
    .b_resp_i         (b_resp),
    .done_valid_o     (d_v),
    .done_ready_i     (d_rdy),
    .done_idx_o       (d_idx),
    .done_err_o       (d_err),
    .done_bursts_o    (d_bursts),
    .outstanding_o    (outst),
    .busy_o           (busy)
  );

  typedef struct {
    int idx;
    bit last;
  } rec_t;

  typedef struct {
    int idx;
    int err;
    int bursts;
  } done_t;

  rec_t  q[$];
  done_t log_q[$];
  bit    m_err;
  int    m_cnt;
  bit    m_dv;
  done_t m_done;
  bit    cmp_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: behaviour from the queue-level rules.
  always @(posedge clk) begin
    bit    aw_ok, b_ok, push, pop, acc, bad;
    rec_t  h;
    if (!rst_n) begin
      q.delete();
      m_err = 0;
      m_cnt = 0;
      m_dv  = 0;
      m_done = '{0, 0, 0};
    end else begin
      aw_ok = q.size() < D;
      b_ok  = (q.size() > 0) && !(m_dv && !d_rdy);
      push  = aw_v && aw_ok;
      pop   = b_v && b_ok;
      acc   = m_dv && d_rdy;
      if (acc) log_q.push_back(m_done);
      if (acc) m_dv = 0;
      if (pop) begin
        h   = q.pop_front();
        bad = (b_resp >= 2);
        if (h.last) begin
          m_done.idx    = h.idx;
          m_done.err    = int'(m_err | bad);
          m_done.bursts = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
          m_dv  = 1;
          m_err = 0;
          m_cnt = 0;
        end else begin
          m_err = m_err | bad;
          m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
        end
      end
      if (push) q.push_back('{int'(aw_idx), aw_last});
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("aw_ready", int'(aw_rdy), int'(q.size() < D));
      chk("b_ready", int'(b_rdy),
          int'(q.size() > 0 && !(m_dv && !d_rdy)));
      chk("outstanding", int'(outst), q.size());
      chk("done_valid", int'(d_v), int'(m_dv));
      chk("busy", int'(busy), int'(q.size() > 0 || m_dv));
      if (m_dv) begin
        chk("done_idx", int'(d_idx), m_done.idx);
        chk("done_err", int'(d_err), m_done.err);
        chk("done_bursts", int'(d_bursts), m_done.bursts);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input int idx, input bit last);
    aw_v    = 1;
    aw_idx  = 4'(idx);
    aw_last = last;
    tick();
    aw_v = 0;
  endtask

  task automatic bresp(input logic [1:0] r);
    b_v    = 1;
    b_resp = r;
    tick();
    b_v = 0;
  endtask

  done_t exp_log[5];

  initial begin
    rst_n = 0; aw_v = 0; aw_idx = 0; aw_last = 0;
    b_v = 0; b_resp = 0; d_rdy = 1;
    tick(2);
    rst_n = 1;
    cmp_en = 1;
    // 1: idle after reset
    chk("rst_aw_ready", int'(aw_rdy), 1);
    chk("rst_b_ready", int'(b_rdy), 0);
    chk("rst_done_valid", int'(d_v), 0);
    chk("rst_outstanding", int'(outst), 0);
    tick();
    // 2: three-burst request, idx 3
    issue(3, 0); issue(3, 0); issue(3, 1);
    chk("t2_outstanding3", int'(outst), 3);
    bresp(2'b00);
    chk("t2_outstanding2", int'(outst), 2);
    bresp(2'b01);
    bresp(2'b00);
    chk("t2_done_1cyc", int'(d_v), 1);
    chk("t2_done_idx", int'(d_idx), 3);
    chk("t2_done_bursts", int'(d_bursts), 3);
    tick(2);
    // 3: error then cleared accumulator
    issue(5, 0); issue(5, 1);
    bresp(2'b10); bresp(2'b00);
    chk("t3_done_err", int'(d_err), 1);
    issue(6, 1);
    bresp(2'b00);
    chk("t3_err_cleared", int'(d_err), 0);
    tick(2);
    // 4: fill to depth, refused 9th issue
    for (int i = 0; i < D; i++) issue(7, i == D - 1);
    chk("t4_full_ready", int'(aw_rdy), 0);
    chk("t4_full_outst", int'(outst), 8);
    issue(9, 1);
    chk("t4_ignored_outst", int'(outst), 8);
    bresp(2'b00);
    chk("t4_ready_back", int'(aw_rdy), 1);
    b_v = 1; b_resp = 2'b00;
    tick(D - 1);
    b_v = 0;
    tick(2);
    // 5: stalled frontend with two one-burst requests
    d_rdy = 0;
    issue(1, 1); issue(2, 1);
    b_v = 1; b_resp = 2'b00;
    tick(4);
    chk("t5_held_valid", int'(d_v), 1);
    chk("t5_held_idx", int'(d_idx), 1);
    chk("t5_b_blocked", int'(b_rdy), 0);
    d_rdy = 1;
    tick();
    chk("t5_next_idx", int'(d_idx), 2);
    chk("t5_no_bubble", int'(d_v), 1);
    b_v = 0;
    tick(3);
    // 6: reset with work in flight
    for (int i = 0; i < 4; i++) issue(4, 0);
    chk("t6_outst4", int'(outst), 4);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("t6_rst_outst", int'(outst), 0);
    chk("t6_rst_done", int'(d_v), 0);
    tick(3);
    cmp_en = 0;
    exp_log[0] = '{3, 0, 3};
    exp_log[1] = '{5, 1, 2};
    exp_log[2] = '{6, 0, 1};
    exp_log[3] = '{7, 0, 8};
    exp_log[4] = '{1, 0, 1};
    chk("log_count", log_q.size(), 6);
    for (int i = 0; i < 5; i++) begin
      if (i < log_q.size()) begin
        chk("log_idx", log_q[i].idx, exp_log[i].idx);
        chk("log_err", log_q[i].err, exp_log[i].err);
        chk("log_bursts", log_q[i].bursts, exp_log[i].bursts);
      end
    end
    if (log_q.size() > 5) chk("log_last_idx", log_q[5].idx, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
